// File: rtl/frb_burst_sequencer.sv
// Burst sequencer for the synthetic-FRB address counter: plays N address sweeps
// separated by a programmable idle gap, with abort and drain handling.
module frb_burst_sequencer #(
  parameter int BURST_W = 16,
  parameter int GAP_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BURST_W-1:0] n_bursts,
  input  logic [GAP_W-1:0]   gap_cycles,
  input  logic [31:0]        decimate_cfg,
  input  logic               cnt_finish,
  output logic               cnt_en,
  output logic [31:0]        cnt_decimate,
  output logic               busy,
  output logic               burst_start,
  output logic [BURST_W-1:0] burst_idx,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] n_bursts_q, n_bursts_d;
  logic [GAP_W-1:0]   gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        dec_q, dec_d;
  logic [BURST_W-1:0] idx_q, idx_d;
  logic               abort_flag_q, abort_flag_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               burst_start_q, burst_start_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               drain_abort;

  // An abort arriving in the final drain cycle still ends the sequence.
  assign drain_abort = abort_flag_q | abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      n_bursts_q    <= '0;
      gap_cfg_q     <= '0;
      gap_cnt_q     <= '0;
      dec_q         <= '0;
      idx_q         <= '0;
      abort_flag_q  <= 1'b0;
      drain_cnt_q   <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      burst_start_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_bursts_q    <= n_bursts_d;
      gap_cfg_q     <= gap_cfg_d;
      gap_cnt_q     <= gap_cnt_d;
      dec_q         <= dec_d;
      idx_q         <= idx_d;
      abort_flag_q  <= abort_flag_d;
      drain_cnt_q   <= drain_cnt_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      burst_start_q <= burst_start_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && !abort) state_d = RUN;
      RUN:   if (abort || cnt_finish) state_d = DRAIN;
      DRAIN: begin
        // Hold at least two cycles and until the counter has dropped finish.
        if (drain_cnt_q && !cnt_finish) begin
          if (drain_abort)                                  state_d = IDLE;
          else if ((n_bursts_q != '0) && (idx_q == n_bursts_q)) state_d = IDLE;
          else if (gap_cfg_q == '0)                         state_d = RUN;
          else                                              state_d = GAP;
        end
      end
      GAP: begin
        if (abort)                          state_d = DRAIN;
        else if (gap_cnt_q <= GAP_W'(1))    state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_bursts_d    = n_bursts_q;
    gap_cfg_d     = gap_cfg_q;
    gap_cnt_d     = gap_cnt_q;
    dec_d         = dec_q;
    idx_d         = idx_q;
    abort_flag_d  = abort_flag_q;
    drain_cnt_d   = drain_cnt_q;
    en_d          = (state_d == RUN);
    busy_d        = (state_d != IDLE);
    burst_start_d = (state_d == RUN) && (state_q != RUN);
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == RUN) begin
          n_bursts_d   = n_bursts;
          gap_cfg_d    = gap_cycles;
          dec_d        = decimate_cfg;
          idx_d        = '0;
          abort_flag_d = 1'b0;
        end
      end
      RUN: begin
        if (cnt_finish) idx_d = idx_q + BURST_W'(1);
        if (state_d == DRAIN) begin
          drain_cnt_d  = 1'b0;
          abort_flag_d = abort;
        end
      end
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (abort) abort_flag_d = 1'b1;
        if (state_d == GAP) gap_cnt_d = gap_cfg_q;
        if (state_d == IDLE) begin
          done_d    = !drain_abort;
          aborted_d = drain_abort;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (state_d == DRAIN) begin
          drain_cnt_d  = 1'b0;
          abort_flag_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cnt_en       = en_q;
  assign cnt_decimate = dec_q;
  assign busy         = busy_q;
  assign burst_start  = burst_start_q;
  assign burst_idx    = idx_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_frb_burst_sequencer.sv
// Randomised and directed bench for frb_burst_sequencer with a scoreboard of
// expected burst_start / done / aborted events and a simple address counter.
module tb_frb_burst_sequencer;

  localparam int BW = 16;
  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [BW-1:0] n_bursts;
  logic [GW-1:0] gap_cycles;
  logic [31:0]   decimate_cfg;
  logic          cnt_finish;
  logic          cnt_en;
  logic [31:0]   cnt_decimate;
  logic          busy;
  logic          burst_start;
  logic [BW-1:0] burst_idx;
  logic          done;
  logic          aborted;

  frb_burst_sequencer #(.BURST_W(BW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_bursts(n_bursts), .gap_cycles(gap_cycles), .decimate_cfg(decimate_cfg),
    .cnt_finish(cnt_finish), .cnt_en(cnt_en), .cnt_decimate(cnt_decimate),
    .busy(busy), .burst_start(burst_start), .burst_idx(burst_idx),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Address counter stand-in: sweeps cnt_len addresses while enabled, holds
  // finish high until it sees en low.
  int cnt_len;
  int addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= 0;
      cnt_finish <= 1'b0;
    end else if (!cnt_en) begin
      addr       <= 0;
      cnt_finish <= 1'b0;
    end else if (!cnt_finish) begin
      if (addr == cnt_len - 1) cnt_finish <= 1'b1;
      else                     addr <= addr + 1;
    end
  end

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] dec;
    int          low;
    logic        busy_v;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void pushEv(input int kind, input int idx, input logic [31:0] dec,
                                 input int low, input logic b);
    ev_t e;
    e.kind = kind; e.idx = idx; e.dec = dec; e.low = low; e.busy_v = b;
    exp_q.push_back(e);
  endfunction

  // A clean sequence: n bursts, en low for 2 + gap between them, then done.
  function automatic void pushSeq(input int n, input int g, input logic [31:0] d);
    pushEv(0, 0, d, -1, 1'b1);
    for (int k = 1; k < n; k++) pushEv(0, k, d, 2 + g, 1'b1);
    pushEv(1, n, d, -1, 1'b0);
  endfunction

  // Monitor: compares every observed event against the head of the queue.
  int   low_cnt = 0;
  logic prev_bs = 1'b0, prev_done = 1'b0, prev_ab = 1'b0;
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (!rst) begin
      if (prev_done) checkOutput("done_width", done, 0);
      if (prev_ab)   checkOutput("aborted_width", aborted, 0);
      if (prev_bs)   checkOutput("burst_start_width", burst_start, 0);
      if (burst_start || done || aborted) begin
        kind = burst_start ? 0 : (done ? 1 : 2);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_event: got kind %0d idx %0d, expected none at %0t",
                   kind, burst_idx, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ev_kind", kind, e.kind);
          checkOutput("ev_burst_idx", burst_idx, e.idx);
          checkOutput("ev_cnt_decimate", cnt_decimate, e.dec);
          checkOutput("ev_busy", busy, e.busy_v);
          if (e.low >= 0) checkOutput("en_low_len", low_cnt, e.low);
        end
      end
    end
    prev_bs   = burst_start;
    prev_done = done;
    prev_ab   = aborted;
    if (cnt_en) low_cnt = 0;
    else        low_cnt++;
  end

  // Pulse start with the given config, then scramble the config inputs.
  task automatic applyStimulus(input int n, input int g, input logic [31:0] d, input int len);
    cnt_len      = len;
    n_bursts     = BW'(n);
    gap_cycles   = GW'(g);
    decimate_cfg = d;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    n_bursts     = BW'($urandom_range(1, 9));
    gap_cycles   = GW'($urandom_range(0, 20));
    decimate_cfg = $urandom;
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int c = 0;
    while (busy && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, c);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic runSeq(input int n, input int g, input logic [31:0] d, input int len);
    pushSeq(n, g, d);
    applyStimulus(n, g, d, len);
    waitIdle(5000, "seq");
    checkOutput("final_burst_idx", burst_idx, n);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    n_bursts = '0; gap_cycles = '0; decimate_cfg = '0; cnt_len = 4;
    repeat (2) @(negedge clk);
    checkOutput("rst_cnt_en", cnt_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_burst_start", burst_start, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_burst_idx", burst_idx, 0);
    checkOutput("rst_cnt_decimate", cnt_decimate, 0);
    rst = 1'b0;
    @(negedge clk);

    // start together with abort is refused
    abort = 1'b1; n_bursts = 16'd2; decimate_cfg = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_en", cnt_en, 0);
    checkOutput("start_abort_dec", cnt_decimate, 0);
    @(negedge clk);

    runSeq(3, 5, 32'd0, 4);
    runSeq(2, 0, 32'd13, 3);

    // abort coincident with finish in burst 1 of 5
    pushEv(0, 0, 32'd9, -1, 1'b1);
    pushEv(2, 1, 32'd9, -1, 1'b0);
    applyStimulus(5, 3, 32'd9, 4);
    c = 0;
    while (!cnt_finish && c < 200) begin @(negedge clk); c++; end
    checkOutput("finish_seen", cnt_finish, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_run_en", cnt_en, 0);
    waitIdle(200, "abort_run");
    checkOutput("abort_run_idx", burst_idx, 1);

    // endless run aborted in the gap after the 4th burst
    for (int k = 0; k < 4; k++) pushEv(0, k, 32'd5, (k == 0) ? -1 : 12, 1'b1);
    pushEv(2, 4, 32'd5, -1, 1'b0);
    applyStimulus(0, 10, 32'd5, 3);
    c = 0;
    while (burst_idx != 4 && c < 2000) begin @(negedge clk); c++; end
    checkOutput("reach_idx4", burst_idx, 4);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    checkOutput("gap_en", cnt_en, 0);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_drain1_en", cnt_en, 0);
    checkOutput("abort_drain1_busy", busy, 1);
    @(negedge clk);
    checkOutput("abort_drain2_en", cnt_en, 0);
    waitIdle(200, "abort_gap");
    checkOutput("abort_gap_idx", burst_idx, 4);

    // start and config changes during RUN are ignored
    pushSeq(2, 4, 32'd7);
    applyStimulus(2, 4, 32'd7, 5);
    @(negedge clk);
    start = 1'b1; decimate_cfg = 32'd99;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midrun_dec", cnt_decimate, 7);
    waitIdle(2000, "restart_ignored");
    checkOutput("midrun_idx", burst_idx, 2);

    for (int i = 0; i < 6; i++)
      runSeq($urandom_range(1, 4), $urandom_range(0, 6), $urandom, $urandom_range(1, 8));

    // async reset in the middle of a burst
    pushEv(0, 0, 32'd11, -1, 1'b1);
    applyStimulus(3, 2, 32'd11, 6);
    @(negedge clk);
    checkOutput("pre_rst_en", cnt_en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_en", cnt_en, 0);
    checkOutput("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_rst_idx", burst_idx, 0);
    checkOutput("post_rst_dec", cnt_decimate, 0);
    @(negedge clk);
    runSeq(2, 1, 32'd3, 3);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
